// File: rtl/co2_alarm_ctrl_pkg.sv
// Shared encodings and defaults for the CO2 alarm controller and its buzzer generator.
package co2_alarm_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WATCH = 2'd1;
    localparam logic [1:0] ST_ALARM = 2'd2;
    localparam logic [1:0] ST_ACKED = 2'd3;

    localparam logic [1:0] LVL_NONE = 2'd0;
    localparam logic [1:0] LVL_LOW  = 2'd1;
    localparam logic [1:0] LVL_MED  = 2'd2;
    localparam logic [1:0] LVL_HIGH = 2'd3;

    localparam int DEF_WINDOW   = 64;
    localparam int DEF_THRESH   = 3;
    localparam int DEF_BEEP_ON  = 8;
    localparam int DEF_BEEP_OFF = 8;
    localparam int DEF_HOLD     = 32;

    // Counter width for a count of v, never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/co2_alarm_ctrl_if.sv
// Detector-side inputs and alarm/status outputs of the CO2 alarm controller.
interface co2_alarm_ctrl_if;
    logic       Z;
    logic       ACK;
    logic       ALARM;
    logic       BUZZER;
    logic [1:0] LEVEL;
    logic [7:0] DET_CNT;

    modport master (output Z, ACK, input ALARM, BUZZER, LEVEL, DET_CNT);
    modport slave  (input Z, ACK, output ALARM, BUZZER, LEVEL, DET_CNT);
endinterface

// File: rtl/co2_beep_gen.sv
// Periodic buzzer: BEEP_ON cycles high then BEEP_OFF low while enabled; restart re-enters the high phase.
// Registered output, one cycle after en/restart; no backpressure.
module co2_beep_gen
    import co2_alarm_pkg::*;
#(
    parameter int BEEP_ON  = DEF_BEEP_ON,
    parameter int BEEP_OFF = DEF_BEEP_OFF
) (
    input  logic CLK,
    input  logic RST,
    input  logic en,
    input  logic restart,
    output logic BUZZER
);

    localparam int PERIOD = BEEP_ON + BEEP_OFF;
    localparam int PW     = cnt_w(PERIOD);
    localparam logic [PW-1:0] LAST   = PW'(PERIOD - 1);
    localparam logic [PW-1:0] ON_LIM = PW'(BEEP_ON);

    logic [PW-1:0] phase_q, phase_d;
    logic          buz_q, buz_d;

    // phase tracks the position of the cycle being presented on BUZZER
    always_comb begin
        phase_d = '0;
        buz_d   = 1'b0;
        if (en) begin
            if (restart || phase_q == LAST) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
            buz_d = (phase_d < ON_LIM);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            phase_q <= '0;
            buz_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            buz_q   <= buz_d;
        end
    end

    assign BUZZER = buz_q;

endmodule

// File: rtl/co2_alarm_ctrl.sv
// Qualifies CO2 detection pulses into an alarm with buzzer, severity level, ack/hold and lifetime count.
// Outputs registered, 1-cycle latency from the sampling edge; Z and ACK are always accepted (no backpressure).
module co2_alarm_ctrl
    import co2_alarm_pkg::*;
#(
    parameter int WINDOW   = DEF_WINDOW,
    parameter int THRESH   = DEF_THRESH,
    parameter int BEEP_ON  = DEF_BEEP_ON,
    parameter int BEEP_OFF = DEF_BEEP_OFF,
    parameter int HOLD     = DEF_HOLD
) (
    input  logic             CLK,
    input  logic             RST,
    co2_alarm_ctrl_if.slave  bus
);

    localparam int WW = cnt_w(WINDOW);
    localparam int HW = cnt_w(HOLD);
    localparam logic [WW-1:0] WIN_INIT  = WW'(WINDOW - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD - 1);
    localparam logic [3:0]    THR       = 4'(THRESH);

    logic          z_q;
    logic [1:0]    state_q, state_d;
    logic [3:0]    hits_q, hits_d, hits_inc;
    logic [WW-1:0] win_q, win_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          alarm_q, alarm_d;
    logic [1:0]    level_q, level_d, level_inc;
    logic [7:0]    det_cnt_q, det_cnt_d;
    logic          det, beep_restart, beep_en, buzzer;

    assign det       = bus.Z & ~z_q;
    assign hits_inc  = hits_q + 4'(det);
    assign level_inc = (level_q == LVL_HIGH) ? LVL_HIGH : level_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        hits_d       = hits_q;
        win_d        = win_q;
        hold_d       = hold_q;
        alarm_d      = alarm_q;
        level_d      = level_q;
        beep_restart = 1'b0;
        det_cnt_d    = det_cnt_q;
        if (det && det_cnt_q != 8'hFF) begin
            det_cnt_d = det_cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                hits_d  = '0;
                win_d   = '0;
                hold_d  = '0;
                alarm_d = 1'b0;
                level_d = LVL_NONE;
                if (det) begin
                    state_d = ST_WATCH;
                    hits_d  = 4'd1;
                    win_d   = WIN_INIT;
                end
            end
            ST_WATCH: begin
                // reaching the threshold wins over a same-cycle window expiry
                if (det && hits_inc == THR) begin
                    state_d      = ST_ALARM;
                    alarm_d      = 1'b1;
                    level_d      = LVL_LOW;
                    hits_d       = '0;
                    win_d        = '0;
                    beep_restart = 1'b1;
                end else if (win_q == '0) begin
                    if (det) begin
                        hits_d = 4'd1;
                        win_d  = WIN_INIT;
                    end else begin
                        state_d = ST_IDLE;
                        hits_d  = '0;
                    end
                end else begin
                    hits_d = hits_inc;
                    win_d  = win_q - WW'(1);
                end
            end
            ST_ALARM: begin
                alarm_d = 1'b1;
                if (det) begin
                    level_d = level_inc;
                end
                if (bus.ACK) begin
                    state_d = ST_ACKED;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_ACKED: begin
                alarm_d = 1'b1;
                if (det) begin
                    state_d      = ST_ALARM;
                    level_d      = level_inc;
                    beep_restart = 1'b1;
                end else if (hold_q == '0) begin
                    state_d = ST_IDLE;
                    alarm_d = 1'b0;
                    level_d = LVL_NONE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hits_d  = '0;
                win_d   = '0;
                hold_d  = '0;
                alarm_d = 1'b0;
                level_d = LVL_NONE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            z_q       <= 1'b0;
            state_q   <= ST_IDLE;
            hits_q    <= '0;
            win_q     <= '0;
            hold_q    <= '0;
            alarm_q   <= 1'b0;
            level_q   <= LVL_NONE;
            det_cnt_q <= '0;
        end else begin
            z_q       <= bus.Z;
            state_q   <= state_d;
            hits_q    <= hits_d;
            win_q     <= win_d;
            hold_q    <= hold_d;
            alarm_q   <= alarm_d;
            level_q   <= level_d;
            det_cnt_q <= det_cnt_d;
        end
    end

    // buzzer follows the next state so it is high on the very first ALARM cycle
    assign beep_en = (state_d == ST_ALARM);

    co2_beep_gen #(
        .BEEP_ON  (BEEP_ON),
        .BEEP_OFF (BEEP_OFF)
    ) u_beep (
        .CLK     (CLK),
        .RST     (RST),
        .en      (beep_en),
        .restart (beep_restart),
        .BUZZER  (buzzer)
    );

    assign bus.ALARM   = alarm_q;
    assign bus.BUZZER  = buzzer;
    assign bus.LEVEL   = level_q;
    assign bus.DET_CNT = det_cnt_q;

endmodule
